sodor_mem_arbiter: RTL
======================

SODOR_MEM_ARBITER -- requirements
Module: sodor_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width in bits.
REQ-002 SHALL have parameter NUM_PORTS, default 2, requester count (range 1..8).
REQ-003 SHALL have parameter DEPTH_WORDS, default 4096, memory depth in words (power of two).
REQ-004 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (range 1..4).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_PORTS, per-port request valid.
REQ-008 SHALL have port req_ready, output, NUM_PORTS, per-port request accepted this cycle.
REQ-009 SHALL have port req_addr, input, NUM_PORTS*XLEN, byte addresses, port i at [i*XLEN +: XLEN].
REQ-010 SHALL have port req_wdata, input, NUM_PORTS*XLEN, write data, same packing.
REQ-011 SHALL have port req_wen, input, NUM_PORTS, 1 = write, 0 = read.
REQ-012 SHALL have port resp_valid, output, NUM_PORTS, per-port one-cycle response strobe.
REQ-013 SHALL have port resp_rdata, output, NUM_PORTS*XLEN, read data, same packing.
REQ-014 SHALL have ports mem_en (output, 1), mem_wen (output, 1), mem_addr (output, clog2(DEPTH_WORDS)), mem_wdata (output, XLEN) and mem_rdata (input, XLEN) forming a single synchronous memory port.
REQ-015 SHALL have port stat_grants, output, NUM_PORTS*32, per-port grant counters.

Function
REQ-016 SHALL grant at most one request per cycle, round-robin, starting the search at the port after the last granted port.
REQ-017 SHALL assert req_ready[i] combinationally in the cycle port i is granted; transfer occurs on req_valid & req_ready.
REQ-018 SHALL grant a lone requester in the same cycle, regardless of pointer position.
REQ-019 SHALL wrap the round-robin pointer from NUM_PORTS-1 to 0.
REQ-020 SHALL drive mem_en=1, mem_wen=req_wen, mem_addr=req_addr[clog2(DEPTH_WORDS)+1:2] and mem_wdata of the granted port in the grant cycle; low 2 address bits are ignored and upper bits wrap modulo DEPTH_WORDS.
REQ-021 SHALL carry the granted port ID and op type through an RD_LAT-deep shift pipeline.
REQ-022 SHALL pulse resp_valid to the originating port exactly RD_LAT cycles after grant, one response per accepted request, in grant order.
REQ-023 SHALL present mem_rdata on resp_rdata for reads; writes SHALL also pulse resp_valid, with resp_rdata=0.
REQ-024 SHALL hold resp_rdata of a port at 0 whenever its resp_valid is 0.
REQ-025 SHALL sustain full throughput: one grant every cycle while any req_valid is high.
REQ-026 SHALL require requesters to hold addr, wdata and wen stable while valid and not ready; a valid withdrawn before grant is legal and ignored.

Reset
REQ-027 SHALL, on rst, clear the pointer to port 0, clear the pipeline (in-flight responses dropped), and drive req_ready=0, resp_valid=0, mem_en=0 and stat_grants=0 immediately.
REQ-028 SHALL grant on the first rising edge after rst deasserts, with port 0 at highest priority.

Configuration
REQ-029 SHALL, with SODOR_ARB_STATS_EN defined, increment stat_grants[i] by 1 per grant to port i, saturating at 0xFFFFFFFF.
REQ-030 SHALL, without SODOR_ARB_STATS_EN defined, keep the stat_grants port present but tie it to 0, with no counter flops.

Structure
REQ-031 SHALL take the port-ID width function, op-type constants (OP_RD=0, OP_WR=1) and the pipeline entry typedef from shared package sodor_mem_pkg.
REQ-032 SHALL implement round-robin selection in sub-module sodor_rr_arbiter (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-033 SHALL verify, with NUM_PORTS=2 and RD_LAT=1: port0 writes 0xDEADBEEF to 0x40, then reads 0x40 -> resp_valid[0] 1 cycle after each grant, with read data 0xDEADBEEF.
REQ-034 SHALL verify, with 4 ports holding req_valid continuously for 8 cycles: grants follow 0,1,2,3,0,1,2,3, and each stat_grants entry reads 2.
REQ-035 SHALL verify, with RD_LAT=3 and back-to-back reads from ports 1 then 0: responses arrive 3 cycles after each grant, in order, to the correct ports.
REQ-036 SHALL verify, with DEPTH_WORDS=16: a write to address 0x44 followed by a read of 0x04 returns the written word (wrap); a read of 0x07 returns the same word (low bits ignored).
REQ-037 SHALL verify rst asserted while 2 reads are in flight -> no resp_valid until new requests arrive, and the pointer returns to 0.
REQ-038 SHALL verify, with SODOR_ARB_STATS_EN undefined: stat_grants stays 0 under full load.

Source files
------------

// File: rtl/sodor_mem_pkg.sv
// Shared types and helpers for the Sodor memory arbiter: op-type codes, the
// port-ID width function and the response pipeline entry.
package sodor_mem_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Widest port ID needed for the supported range of 1..8 requesters.
    localparam int unsigned MAX_PORT_W = 3;

    function automatic int unsigned port_id_w(input int unsigned num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic                  op;
        logic [MAX_PORT_W-1:0] port;
    } pipe_entry_t;

endpackage

// File: rtl/sodor_rr_arbiter.sv
// Round-robin selector: one-hot grant of the first requester at or after ptr,
// wrapping to the lowest-numbered requester when none is found above it.
module sodor_rr_arbiter
    import sodor_mem_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PW        = port_id_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    int   ptr_int;
    logic found;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        ptr_int = int'(ptr);
        // First pass covers ports ptr..N-1; second pass wraps to 0..ptr-1.
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (!found && req[j] && (j >= ptr_int)) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sodor_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port among NUM_PORTS requesters.
// Define SODOR_ARB_STATS_EN to enable the saturating per-port grant counters.
module sodor_mem_arbiter
    import sodor_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS*XLEN-1:0]     req_addr,
    input  logic [NUM_PORTS*XLEN-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0]          req_wen,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [NUM_PORTS*XLEN-1:0]     resp_rdata,
    output logic                          mem_en,
    output logic                          mem_wen,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [XLEN-1:0]               mem_wdata,
    input  logic [XLEN-1:0]               mem_rdata,
    output logic [NUM_PORTS*32-1:0]       stat_grants
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = port_id_w(NUM_PORTS);

    logic [PW-1:0]        ptr_q, ptr_d, gnt_idx;
    logic [NUM_PORTS-1:0] req_live, gnt;
    logic                 any_gnt, sel_wen;
    logic [XLEN-1:0]      sel_addr, sel_wdata;
    pipe_entry_t          new_entry, head;
    pipe_entry_t          pipe_q [RD_LAT];

    // Requests are masked during reset so ready and mem_en drop immediately.
    assign req_live = req_valid & {NUM_PORTS{~rst}};

    sodor_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_rr (
        .req (req_live),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (gnt[i]) begin
                gnt_idx   = PW'(i);
                sel_addr  = req_addr[i*XLEN +: XLEN];
                sel_wdata = req_wdata[i*XLEN +: XLEN];
                sel_wen   = req_wen[i];
            end
        end
        any_gnt = |gnt;
        ptr_d   = ptr_q;
        if (any_gnt) begin
            ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign req_ready = gnt;
    assign mem_en    = any_gnt;
    assign mem_wen   = any_gnt & sel_wen;
    assign mem_addr  = sel_addr[AW+1:2];
    assign mem_wdata = sel_wdata;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = any_gnt;
        new_entry.op    = sel_wen ? OP_WR : OP_RD;
        new_entry.port  = MAX_PORT_W'(gnt_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int s = 0; s < int'(RD_LAT); s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            pipe_q[0] <= new_entry;
            for (int s = 1; s < int'(RD_LAT); s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign head = pipe_q[RD_LAT-1];

    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (head.valid && (head.port == MAX_PORT_W'(i))) begin
                resp_valid[i] = 1'b1;
                if (head.op == OP_RD) begin
                    resp_rdata[i*XLEN +: XLEN] = mem_rdata;
                end
            end
        end
    end

`ifdef SODOR_ARB_STATS_EN
    logic [NUM_PORTS-1:0][31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (gnt[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign stat_grants = cnt_q;
`else
    assign stat_grants = '0;
`endif

endmodule
